// File: rtl/burst_mem_responder.sv
// burst_mem_responder: memory-side responder for the 4-beat x 64-bit line
// burst protocol. It holds 2^MEM_LINES_LOG2 lines of 256 bits. A read returns
// four ascending beats. A write accepts four ascending beats. Each beat is
// qualified by resp_o. The first beat arrives LATENCY cycles after the
// request first appears.
//
// Optional build macro BURST_MEM_STALL_EN: a free-running 8-bit LFSR inserts
// pseudo-random stall cycles inside a burst. The beat count and beat order
// stay the same.
module burst_mem_responder #(
  parameter int MEM_LINES_LOG2 = 10,
  parameter int LATENCY        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address_i,
  input  logic        read_i,
  input  logic        write_i,
  input  logic [63:0] burst_i,
  output logic [63:0] burst_o,
  output logic        resp_o
);

  localparam int LINES = 1 << MEM_LINES_LOG2;
  // WAIT lasts LATENCY-1 cycles, so the counter is loaded with LATENCY-2.
  localparam logic [3:0] LAT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [MEM_LINES_LOG2-1:0] r_idx;
  logic [MEM_LINES_LOG2-1:0] w_idx_next;
  logic                      r_is_read;
  logic                      w_is_read_next;
  logic [1:0]                r_beat;
  logic [1:0]                w_beat_next;
  logic [3:0]                r_lat_cnt;
  logic [3:0]                w_lat_cnt_next;
  logic                      r_resp;
  logic [63:0]               r_burst;

  logic                      w_req;
  logic                      w_stall_next;
  logic                      w_resp_next;
  logic                      w_commit;
  logic [255:0]              w_rd_line;
  logic [63:0]               w_burst_next;
  logic                      w_unused_addr;

  // NOTE: The store is intentionally left out of the reset, so contents survive rst.
  // The declaration initializer gives a zero power-up image.
  // FPGA tools honour it as block-RAM init content.
  logic [255:0] r_mem [LINES] = '{default: '0};

  // Offset bits and the aliasing upper bits do not take part in addressing.
  assign w_unused_addr = ^{address_i[31:5+MEM_LINES_LOG2], address_i[4:0]};

  // A transaction stays alive only while the requester holds a request level.
  assign w_req = read_i | write_i;

  // A beat is live in the current cycle exactly when the registered strobe is high.
  assign w_commit = (r_state == S_BURST) && r_resp && w_req;

`ifdef BURST_MEM_STALL_EN
  logic [7:0] r_lfsr;
  logic [7:0] w_lfsr_next;

  // Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  // Outputs are registered, so the next cycle's stall is decided from the next LFSR value.
  assign w_stall_next = (w_lfsr_next[1:0] == 2'b00);

  // Advance the stall LFSR every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= w_lfsr_next;
    end
  end
`else
  assign w_stall_next = 1'b0;
`endif

  // Next-state and next transaction context for the request/beat sequencer.
  always_comb begin
    // NOTE: Every target gets a default first, so no path can leave a latch behind.
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_is_read_next = r_is_read;
    w_beat_next    = r_beat;
    w_lat_cnt_next = r_lat_cnt;

    unique case (r_state)
      S_IDLE: begin
        w_beat_next = 2'd0;
        if (w_req) begin
          // Read wins when both levels are high; the write is dropped.
          w_is_read_next = read_i;
          w_idx_next     = address_i[5+MEM_LINES_LOG2-1:5];
          w_lat_cnt_next = LAT_LOAD;
          w_state_next   = (LATENCY == 1) ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!w_req) begin
          w_state_next = S_IDLE;
        end else if (r_lat_cnt == 4'd0) begin
          w_state_next = S_BURST;
        end else begin
          w_lat_cnt_next = r_lat_cnt - 4'd1;
        end
      end
      S_BURST: begin
        if (!w_req) begin
          w_state_next = S_IDLE;
        end else if (r_resp) begin
          if (r_beat == 2'd3) begin
            w_state_next = S_DONE;
          end else begin
            w_beat_next = r_beat + 2'd1;
          end
        end
      end
      S_DONE: begin
        // Wait for the requester to drop, so a held request is not served twice.
        if (!w_req) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Registered beat strobe and read data for the next cycle.
  assign w_resp_next  = (w_state_next == S_BURST) && !w_stall_next;
  assign w_rd_line    = r_mem[w_idx_next];
  assign w_burst_next = (w_resp_next && w_is_read_next) ?
                        w_rd_line[{w_beat_next, 6'b0} +: 64] : 64'd0;

  // Sequencer state, transaction context and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_is_read <= 1'b0;
      r_beat    <= 2'd0;
      r_lat_cnt <= 4'd0;
      r_resp    <= 1'b0;
      r_burst   <= 64'd0;
    end else begin
      // NOTE: Non-blocking assignments make every register update from pre-edge values.
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_is_read <= w_is_read_next;
      r_beat    <= w_beat_next;
      r_lat_cnt <= w_lat_cnt_next;
      r_resp    <= w_resp_next;
      r_burst   <= w_burst_next;
    end
  end

  // Commit each accepted write beat into its 64-bit lane of the latched line.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && !r_is_read) begin
      r_mem[r_idx][{r_beat, 6'b0} +: 64] <= burst_i;
    end
  end

  assign resp_o  = r_resp;
  assign burst_o = r_burst;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Testbench for burst_mem_responder. It covers table-driven write/read
// transactions, a hand-written reset in the middle of a write, and random
// write/read pairs. Expected read beats go to a scoreboard queue when a read
// is issued. Each resp_o beat pops and compares one entry.
module tb_burst_mem_responder;

  localparam int MEM_LINES_LOG2 = 10;
  localparam int LATENCY        = 3;
  localparam int BUDGET         = 200;

  logic        clk;
  logic        rst;
  logic [31:0] address_i;
  logic        read_i;
  logic        write_i;
  logic [63:0] burst_i;
  logic [63:0] burst_o;
  logic        resp_o;

  int checks;
  int errors;
  int stall_cycles;
  logic [63:0] exp_q[$];

  typedef struct {
    bit           rd;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [255:0] exp_line;
    int           hold;
  } vec_t;

  vec_t vecs[8];

  burst_mem_responder #(
    .MEM_LINES_LOG2(MEM_LINES_LOG2),
    .LATENCY       (LATENCY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .address_i(address_i),
    .read_i   (read_i),
    .write_i  (write_i),
    .burst_i  (burst_i),
    .burst_o  (burst_o),
    .resp_o   (resp_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Run one transaction from a negedge. Read beats go through the scoreboard.
  // After the 4th beat, hold the request 'hold' extra cycles, then drop it.
  task automatic run_txn(input string tag, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [255:0] wline,
                         input logic [255:0] exp_line, input int hold,
                         output int first_at);
    int pulses;
    int cyc;
    logic [63:0] exp_beat;
    pulses   = 0;
    cyc      = 0;
    first_at = -1;
    address_i = addr;
    read_i    = rd;
    write_i   = wr;
    burst_i   = wline[63:0];
    if (rd) begin
      for (int k = 0; k < 4; k++) exp_q.push_back(exp_line[64*k +: 64]);
    end
    while (pulses < 4 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      burst_i = wline[64*pulses +: 64];
      if (resp_o) begin
        if (first_at < 0) first_at = cyc;
        if (rd) begin
          exp_beat = 'x;
          if (exp_q.size() != 0) exp_beat = exp_q.pop_front();
          check({tag, "_read_beat"}, burst_o, exp_beat);
        end
        pulses++;
      end else begin
        check({tag, "_burst_zero_when_idle"}, burst_o, 64'd0);
        if (pulses > 0) stall_cycles++;
      end
    end
    check({tag, "_beat_count"}, 64'(pulses), 64'd4);
    check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    check({tag, "_resp_low_after_burst"}, {63'd0, resp_o}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_done_hold_no_beat"}, {63'd0, resp_o}, 64'd0);
    end
    read_i  = 1'b0;
    write_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] l_a0;
    logic [255:0] l_100;
    logic [255:0] l_dead;
    logic [255:0] old_line;
    logic [255:0] new_line;
    logic [255:0] wl;
    logic [31:0]  ra;
    int first_at;
    int pulses;
    int cyc;

    checks       = 0;
    errors       = 0;
    stall_cycles = 0;

    l_a0   = {64'h4444444444444444, 64'h3333333333333333,
              64'h2222222222222222, 64'h1111111111111111};
    l_100  = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
              64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0};
    l_dead = {4{64'h00000000DEADBEEF}};

    //         rd    wr    addr           wline   exp_line hold
    vecs[0] = '{1'b0, 1'b1, 32'h000000A0, l_a0,   '0,      0};
    vecs[1] = '{1'b1, 1'b0, 32'h000000A0, '0,     l_a0,    3};
    vecs[2] = '{1'b1, 1'b1, 32'h00000040, l_dead, '0,      0};
    vecs[3] = '{1'b1, 1'b0, 32'h00000040, '0,     '0,      0};
    vecs[4] = '{1'b0, 1'b1, 32'h00000100, l_100,  '0,      0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000011F, '0,     l_100,   0};
    vecs[6] = '{1'b1, 1'b0, 32'h00008100, '0,     l_100,   1};
    vecs[7] = '{1'b1, 1'b0, 32'h000000A0, '0,     l_a0,    0};

    rst       = 1'b1;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = 32'd0;
    burst_i   = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_resp", {63'd0, resp_o}, 64'd0);
    check("reset_burst", burst_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr,
              vecs[i].wline, vecs[i].exp_line, vecs[i].hold, first_at);
`ifndef BURST_MEM_STALL_EN
      check($sformatf("v%0d_first_beat_latency", i), 64'(first_at), 64'(LATENCY));
`endif
    end

    // Reset in the cycle after beat 1 of a write. Beats 0 and 1 stay committed.
    // Beat 2 is on the bus during the reset edge and must not land.
    old_line = {64'h5555555555555503, 64'h5555555555555502,
                64'h5555555555555501, 64'h5555555555555500};
    new_line = {64'hAAAAAAAAAAAAAA03, 64'hAAAAAAAAAAAAAA02,
                64'hAAAAAAAAAAAAAA01, 64'hAAAAAAAAAAAAAA00};
    run_txn("rst_prefill", 1'b0, 1'b1, 32'h00000200, old_line, '0, 0, first_at);
    address_i = 32'h00000200;
    write_i   = 1'b1;
    burst_i   = new_line[63:0];
    pulses    = 0;
    cyc       = 0;
    while (pulses < 2 && cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      burst_i = new_line[64*pulses +: 64];
      if (resp_o) pulses++;
    end
    check("rst_beats_before_reset", 64'(pulses), 64'd2);
    @(negedge clk);
    burst_i = new_line[64*pulses +: 64];
    rst     = 1'b1;
    @(negedge clk);
    check("rst_mid_resp", {63'd0, resp_o}, 64'd0);
    check("rst_mid_burst", burst_o, 64'd0);
    rst     = 1'b0;
    write_i = 1'b0;
    @(negedge clk);
    run_txn("rst_readback", 1'b1, 1'b0, 32'h00000200, '0,
            {old_line[255:128], new_line[127:0]}, 0, first_at);

    // Random write/read pairs. Each read expects the line just written.
    for (int n = 0; n < 20; n++) begin
      ra = $urandom;
      wl = {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
      run_txn($sformatf("rnd%0d_wr", n), 1'b0, 1'b1, ra, wl, '0, 0, first_at);
      run_txn($sformatf("rnd%0d_rd", n), 1'b1, 1'b0, ra, '0, wl, 0, first_at);
    end

`ifdef BURST_MEM_STALL_EN
    check("stall_seen", {63'd0, (stall_cycles > 0)}, 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Memory-side responder for the 4-beat x 64-bit burst protocol that the LLC line adaptor initiates.
- Holds a line-organised backing store (2^MEM_LINES_LOG2 lines x 256 bits).
- Serves a read request with 4 data beats and accepts a write request as 4 data beats, each beat qualified by resp_o.
- Used as the main-memory model in simulation and as FPGA block-RAM main memory.

Parameters:
- MEM_LINES_LOG2, 10: number of line index bits; store depth is 2^MEM_LINES_LOG2 lines.
- LATENCY, 3: cycles from the first request cycle to the first beat; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- address_i  input  32  byte address, held constant by the requester for the whole transaction.
- read_i  input  1  read request, level; held until the 4th beat's resp_o.
- write_i  input  1  write request, level; held until the 4th beat's resp_o.
- burst_i  input  64  write data for the current beat.
- burst_o  output  64  read data for the current beat; 0 whenever resp_o=0.
- resp_o  output  1  beat valid/accepted strobe; one pulse per beat.

Behaviour:
- Addressing:
  - Line index = address_i[5+MEM_LINES_LOG2-1:5].
  - Bits [4:0] are ignored.
  - Upper bits above the index are ignored, so addresses alias modulo the store size.
- Beat order: beat k maps to line bits [64k+63:64k], k = 0..3, always ascending.
- resp_o and burst_o are registered. Reset values: resp_o=0, burst_o=0, state=IDLE, beat counter=0, latency counter=0.
- Store contents are zero at time 0 and are NOT cleared by rst.
- FSM:
  - IDLE: if read_i=1, latch read, load latency counter, go to WAIT. Else if write_i=1, latch write, go to WAIT. Read has priority when both are high; the write is ignored.
  - WAIT: count LATENCY-1 cycles, then enter BURST. With LATENCY=1, go directly from IDLE to BURST.
  - BURST (read): resp_o=1 and burst_o=line[beat] each cycle; beat increments. After beat 3, go to DONE.
  - BURST (write): resp_o=1 each cycle; burst_i is written to line[beat] on that edge; beat increments. After beat 3, go to DONE.
  - DONE: resp_o=0. Stay until read_i=0 and write_i=0, then go to IDLE. This guarantees a held request is never re-served.
- Timing:
  - If read_i/write_i first goes high in cycle c, beats occupy cycles c+LATENCY .. c+LATENCY+3 (back-to-back, no stall).
  - resp_o is low in cycle c+LATENCY+4.
  - A new request is accepted no earlier than 1 cycle after DONE exits.
- Request dropped early (read_i and write_i both low in WAIT or BURST): abort to IDLE next cycle, resp_o=0. Write beats already committed stay committed.
- Reset mid-transaction: next cycle resp_o=0, burst_o=0, state=IDLE. Committed write beats persist; uncommitted beats are lost.
- address_i is sampled each beat (requester holds it constant). The line index latched at request acceptance is used for the whole burst.

Optional Feature:
- Macro: BURST_MEM_STALL_EN.
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; reset value 8'hA5 on rst) advances every cycle.
  - In BURST, when lfsr[1:0]==2'b00, the cycle is a stall: resp_o=0, burst_o=0, no store write, beat unchanged.
  - Still exactly 4 beats per transaction, in order.
- Not defined: no LFSR; beats are strictly back-to-back as above.

Test Plan:
- Write then read: write addr 0x000000A0 with beats 0x1111111111111111, 0x2222222222222222, 0x3333333333333333, 0x4444444444444444, then read 0x000000A0 -> burst_o returns the same 4 values in order, with exactly 4 resp_o pulses each transaction.
- Latency, LATENCY=3: read_i rises in cycle 10 -> resp_o high in cycles 13-16, low in cycle 17; state holds DONE while read_i stays high in cycle 17 and returns to IDLE after read_i falls.
- Simultaneous request: read_i=write_i=1 at 0x40 with burst_i=0xDEADBEEF -> a read is performed and a following read of 0x40 returns the prior contents (zeros at start).
- Reset mid-write: rst=1 in the cycle after beat 1's resp_o while writing 0xAA.. beats to 0x200 -> next cycle resp_o=0; a later read of 0x200 gives beats 0,1 = new data and beats 2,3 = old data.
- Aliasing, MEM_LINES_LOG2=10: write 0x00000100, read 0x0000011F and 0x00008100 -> both return the written line.
- With BURST_MEM_STALL_EN: 20 random write/read pairs -> every read matches the prior write, 4 resp_o pulses per transaction, at least one stall cycle observed.
